// File: rtl/matmul_addr_gen.sv
// matmul_addr_gen: operand-address generator for C = A x B.
// Walks the i/j/k loop nest (k innermost) after a start pulse and emits one
// fetch request (A, B, C byte addresses plus k markers) per multiply-accumulate
// over a valid/ready stream. Addresses are produced incrementally from row-base
// and column-base registers, so there are no multipliers.
// Optional feature: define MATMUL_AGEN_PERF_EN to build the busy-cycle and
// stall-cycle performance counters; otherwise both counter ports read 0.
module matmul_addr_gen #(
   parameter int ADDR_WIDTH = 32,
   parameter int DIM_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  accel_start,
   input  logic                  accel_reset,
   input  logic [ADDR_WIDTH-1:0] matrix_a_addr,
   input  logic [ADDR_WIDTH-1:0] matrix_b_addr,
   input  logic [ADDR_WIDTH-1:0] matrix_c_addr,
   input  logic [DIM_WIDTH-1:0]  m_dim,
   input  logic [DIM_WIDTH-1:0]  k_dim,
   input  logic [DIM_WIDTH-1:0]  n_dim,
   input  logic [7:0]            data_type,
   input  logic [DIM_WIDTH-1:0]  stride_a,
   input  logic [DIM_WIDTH-1:0]  stride_b,
   input  logic [DIM_WIDTH-1:0]  stride_c,
   output logic                  req_valid,
   input  logic                  req_ready,
   output logic [ADDR_WIDTH-1:0] req_addr_a,
   output logic [ADDR_WIDTH-1:0] req_addr_b,
   output logic [ADDR_WIDTH-1:0] req_addr_c,
   output logic                  req_first_k,
   output logic                  req_last_k,
   output logic                  req_final,
   output logic                  accel_busy,
   output logic                  accel_done,
   output logic                  accel_error,
   output logic [31:0]           perf_cycles,
   output logic [31:0]           perf_stalls
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [DIM_WIDTH-1:0]  DIM_ONE  = DIM_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
   localparam int                    PAD_W    = ADDR_WIDTH - DIM_WIDTH;

   state_t                  r_state;
   state_t                  w_nextState;

   logic [DIM_WIDTH-1:0]    r_i;
   logic [DIM_WIDTH-1:0]    r_j;
   logic [DIM_WIDTH-1:0]    r_k;
   logic [DIM_WIDTH-1:0]    r_mLast;
   logic [DIM_WIDTH-1:0]    r_kLast;
   logic [DIM_WIDTH-1:0]    r_nLast;

   logic [ADDR_WIDTH-1:0]   r_baseB;
   logic [ADDR_WIDTH-1:0]   r_rowA;
   logic [ADDR_WIDTH-1:0]   r_rowC;
   logic [ADDR_WIDTH-1:0]   r_colB;
   logic [ADDR_WIDTH-1:0]   r_addrA;
   logic [ADDR_WIDTH-1:0]   r_addrB;
   logic [ADDR_WIDTH-1:0]   r_addrC;
   logic [ADDR_WIDTH-1:0]   r_elem;
   logic [ADDR_WIDTH-1:0]   r_stepA;
   logic [ADDR_WIDTH-1:0]   r_stepB;
   logic [ADDR_WIDTH-1:0]   r_stepC;

   logic                    r_done;
   logic                    r_error;

   logic                    w_idle;
   logic                    w_run;
   logic                    w_cfgValid;
   logic                    w_startOk;
   logic                    w_startBad;
   logic                    w_fire;
   logic                    w_lastK;
   logic                    w_lastJ;
   logic                    w_lastI;
   logic                    w_final;
   logic [1:0]              w_sh;
   logic [ADDR_WIDTH-1:0]   w_elem;
   logic [ADDR_WIDTH-1:0]   w_stepA;
   logic [ADDR_WIDTH-1:0]   w_stepB;
   logic [ADDR_WIDTH-1:0]   w_stepC;

   assign w_idle     = (r_state == ST_IDLE);
   assign w_run      = (r_state == ST_RUN);
   assign w_cfgValid = (m_dim != '0) && (k_dim != '0) && (n_dim != '0) && (data_type <= 8'd2);
   assign w_startOk  = accel_start && !accel_reset && w_idle && w_cfgValid;
   assign w_startBad = accel_start && !accel_reset && w_idle && !w_cfgValid;
   assign w_fire     = w_run && req_ready;
   assign w_lastK    = (r_k == r_kLast);
   assign w_lastJ    = (r_j == r_nLast);
   assign w_lastI    = (r_i == r_mLast);
   assign w_final    = w_lastK && w_lastJ && w_lastI;

   // Element size and per-row pitches in bytes, derived from the start-time config.
   assign w_sh    = data_type[1:0];
   assign w_elem  = ADDR_ONE << w_sh;
   assign w_stepA = {{PAD_W{1'b0}}, stride_a} << w_sh;
   assign w_stepB = {{PAD_W{1'b0}}, stride_b} << w_sh;
   assign w_stepC = {{PAD_W{1'b0}}, stride_c} << w_sh;

   assign req_valid   = w_run;
   assign accel_busy  = w_run;
   assign req_addr_a  = r_addrA;
   assign req_addr_b  = r_addrB;
   assign req_addr_c  = r_addrC;
   assign req_first_k = w_run && (r_k == '0);
   assign req_last_k  = w_run && w_lastK;
   assign req_final   = w_run && w_final;
   assign accel_done  = r_done;
   assign accel_error = r_error;

   // State register for the IDLE/RUN/DONE controller.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: soft reset wins, a job ends when its final request is taken.
   always_comb begin
      w_nextState = r_state;
      if (accel_reset) begin
         w_nextState = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (w_startOk) w_nextState = ST_RUN;
            ST_RUN:  if (w_fire && w_final) w_nextState = ST_DONE;
            ST_DONE: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
         endcase
      end
   end

   // Loop counters and incremental address registers: latch on start, step on each handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_i     <= '0;
         r_j     <= '0;
         r_k     <= '0;
         r_mLast <= '0;
         r_kLast <= '0;
         r_nLast <= '0;
         r_baseB <= '0;
         r_rowA  <= '0;
         r_rowC  <= '0;
         r_colB  <= '0;
         r_addrA <= '0;
         r_addrB <= '0;
         r_addrC <= '0;
         r_elem  <= '0;
         r_stepA <= '0;
         r_stepB <= '0;
         r_stepC <= '0;
      end else if (accel_reset) begin
         r_i     <= '0;
         r_j     <= '0;
         r_k     <= '0;
         r_addrA <= '0;
         r_addrB <= '0;
         r_addrC <= '0;
      end else if (w_startOk) begin
         r_i     <= '0;
         r_j     <= '0;
         r_k     <= '0;
         r_mLast <= m_dim - DIM_ONE;
         r_kLast <= k_dim - DIM_ONE;
         r_nLast <= n_dim - DIM_ONE;
         r_baseB <= matrix_b_addr;
         r_rowA  <= matrix_a_addr;
         r_rowC  <= matrix_c_addr;
         r_colB  <= matrix_b_addr;
         r_addrA <= matrix_a_addr;
         r_addrB <= matrix_b_addr;
         r_addrC <= matrix_c_addr;
         r_elem  <= w_elem;
         r_stepA <= w_stepA;
         r_stepB <= w_stepB;
         r_stepC <= w_stepC;
      end else if (w_fire && !w_final) begin
         if (!w_lastK) begin
            r_k     <= r_k + DIM_ONE;
            r_addrA <= r_addrA + r_elem;
            r_addrB <= r_addrB + r_stepB;
         end else if (!w_lastJ) begin
            r_k     <= '0;
            r_j     <= r_j + DIM_ONE;
            r_colB  <= r_colB + r_elem;
            r_addrB <= r_colB + r_elem;
            r_addrA <= r_rowA;
            r_addrC <= r_addrC + r_elem;
         end else begin
            r_k     <= '0;
            r_j     <= '0;
            r_i     <= r_i + DIM_ONE;
            r_rowA  <= r_rowA + r_stepA;
            r_addrA <= r_rowA + r_stepA;
            r_rowC  <= r_rowC + r_stepC;
            r_addrC <= r_rowC + r_stepC;
            r_colB  <= r_baseB;
            r_addrB <= r_baseB;
         end
      end
   end

   // Sticky done/error flags: set at end of job or on a bad config, cleared by a good start or soft reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
      end else if (accel_reset || w_startOk) begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
      end else if (w_startBad) begin
         r_done  <= 1'b0;
         r_error <= 1'b1;
      end else if (r_state == ST_DONE) begin
         r_done  <= 1'b1;
      end
   end

`ifdef MATMUL_AGEN_PERF_EN
   logic [31:0] r_perfCycles;
   logic [31:0] r_perfStalls;

   assign perf_cycles = r_perfCycles;
   assign perf_stalls = r_perfStalls;

   // Saturating busy and stall counters, restarted with each job.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perfCycles <= '0;
         r_perfStalls <= '0;
      end else if (accel_reset || w_startOk) begin
         r_perfCycles <= '0;
         r_perfStalls <= '0;
      end else begin
         if (w_run && (r_perfCycles != 32'hFFFF_FFFF)) begin
            r_perfCycles <= r_perfCycles + 32'd1;
         end
         if (w_run && !req_ready && (r_perfStalls != 32'hFFFF_FFFF)) begin
            r_perfStalls <= r_perfStalls + 32'd1;
         end
      end
   end
`else
   assign perf_cycles = '0;
   assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_matmul_addr_gen.sv
// tb_matmul_addr_gen: directed and randomized jobs for matmul_addr_gen,
// checked against a loop-nest reference model built from the address formulas.
module tb_matmul_addr_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        accel_start = 1'b0;
   logic        accel_reset = 1'b0;
   logic [31:0] matrix_a_addr = '0;
   logic [31:0] matrix_b_addr = '0;
   logic [31:0] matrix_c_addr = '0;
   logic [15:0] m_dim = '0;
   logic [15:0] k_dim = '0;
   logic [15:0] n_dim = '0;
   logic [7:0]  data_type = '0;
   logic [15:0] stride_a = '0;
   logic [15:0] stride_b = '0;
   logic [15:0] stride_c = '0;
   logic        req_valid;
   logic        req_ready = 1'b1;
   logic [31:0] req_addr_a;
   logic [31:0] req_addr_b;
   logic [31:0] req_addr_c;
   logic        req_first_k;
   logic        req_last_k;
   logic        req_final;
   logic        accel_busy;
   logic        accel_done;
   logic        accel_error;
   logic [31:0] perf_cycles;
   logic [31:0] perf_stalls;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic        first;
      logic        last;
      logic        fin;
   } req_t;

   req_t        expQ[$];
   int          checkCount = 0;
   int          passCount = 0;
   int          stallSeen;
   int          busySeen;

   logic [31:0] cfgA, cfgB, cfgC;
   logic [15:0] cfgM, cfgK, cfgN, cfgSa, cfgSb, cfgSc;
   logic [7:0]  cfgDt;

   matmul_addr_gen #(.ADDR_WIDTH(32), .DIM_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .accel_start(accel_start), .accel_reset(accel_reset),
      .matrix_a_addr(matrix_a_addr), .matrix_b_addr(matrix_b_addr), .matrix_c_addr(matrix_c_addr),
      .m_dim(m_dim), .k_dim(k_dim), .n_dim(n_dim), .data_type(data_type),
      .stride_a(stride_a), .stride_b(stride_b), .stride_c(stride_c),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_addr_c(req_addr_c),
      .req_first_k(req_first_k), .req_last_k(req_last_k), .req_final(req_final),
      .accel_busy(accel_busy), .accel_done(accel_done), .accel_error(accel_error),
      .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Reference model: plain i/j/k loop nest using the byte-address formulas directly.
   task automatic setJob(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [15:0] m, input logic [15:0] k, input logic [15:0] n,
                         input logic [7:0] dt, input logic [15:0] sa, input logic [15:0] sb,
                         input logic [15:0] sc);
      req_t r;
      int   sh;
      cfgA = a; cfgB = b; cfgC = c; cfgM = m; cfgK = k; cfgN = n;
      cfgDt = dt; cfgSa = sa; cfgSb = sb; cfgSc = sc;
      expQ.delete();
      if (m != 0 && k != 0 && n != 0 && dt <= 8'd2) begin
         sh = int'(dt);
         for (int i = 0; i < int'(m); i++)
            for (int j = 0; j < int'(n); j++)
               for (int kk = 0; kk < int'(k); kk++) begin
                  r.a = a + ((32'(i) * 32'(sa) + 32'(kk)) << sh);
                  r.b = b + ((32'(kk) * 32'(sb) + 32'(j)) << sh);
                  r.c = c + ((32'(i) * 32'(sc) + 32'(j)) << sh);
                  r.first = (kk == 0);
                  r.last  = (kk == int'(k) - 1);
                  r.fin   = r.last && (i == int'(m) - 1) && (j == int'(n) - 1);
                  expQ.push_back(r);
               end
      end
   endtask

   // Drive the stored configuration and pulse start for one cycle.
   task automatic applyStimulus();
      @(negedge clk);
      matrix_a_addr = cfgA; matrix_b_addr = cfgB; matrix_c_addr = cfgC;
      m_dim = cfgM; k_dim = cfgK; n_dim = cfgN; data_type = cfgDt;
      stride_a = cfgSa; stride_b = cfgSb; stride_c = cfgSc;
      accel_start = 1'b1;
      @(negedge clk);
      accel_start = 1'b0;
   endtask

   // Consume requests against the model; optional stall, abort point and stray start.
   task automatic runRequests(input int stallAt, input int stallLen, input int abortAfter,
                              input int restartAt, input bit randReady);
      int idx = 0;
      int stallCnt = 0;
      int cyc = 0;
      int limit;
      int target;
      bit pulsed = 1'b0;
      stallSeen = 0;
      busySeen = 0;
      limit = expQ.size() * 8 + 20;
      target = (abortAfter >= 0) ? abortAfter : expQ.size();
      while (idx < target && cyc < limit) begin
         accel_start = 1'b0;
         checkOutput("req_valid during run", 32'(req_valid), 32'd1);
         checkOutput("busy during run", 32'(accel_busy), 32'd1);
         if (req_valid) begin
            checkOutput("req_addr_a", req_addr_a, expQ[idx].a);
            checkOutput("req_addr_b", req_addr_b, expQ[idx].b);
            checkOutput("req_addr_c", req_addr_c, expQ[idx].c);
            checkOutput("req_first_k", 32'(req_first_k), 32'(expQ[idx].first));
            checkOutput("req_last_k", 32'(req_last_k), 32'(expQ[idx].last));
            checkOutput("req_final", 32'(req_final), 32'(expQ[idx].fin));
         end
         if (accel_busy) busySeen++;
         if (restartAt >= 0 && idx == restartAt && !pulsed) begin
            accel_start = 1'b1;
            matrix_a_addr = 32'hDEAD_0000;
            pulsed = 1'b1;
         end
         if (idx == stallAt && stallCnt < stallLen) begin
            req_ready = 1'b0;
            stallCnt++;
         end else if (randReady) begin
            req_ready = ($urandom_range(0, 3) != 0);
         end else begin
            req_ready = 1'b1;
         end
         if (req_valid && !req_ready) stallSeen++;
         if (req_valid && req_ready) idx++;
         cyc++;
         if (idx < target || abortAfter < 0) @(negedge clk);
      end
      accel_start = 1'b0;
      checkOutput("handshake count", 32'(idx), 32'(target));
   endtask

   // After the final handshake: one DONE cycle, then done set with busy low.
   task automatic finishJob();
      checkOutput("req_valid after final", 32'(req_valid), 32'd0);
      checkOutput("busy after final", 32'(accel_busy), 32'd0);
      req_ready = 1'b1;
      @(negedge clk);
      checkOutput("done after job", 32'(accel_done), 32'd1);
      checkOutput("busy after job", 32'(accel_busy), 32'd0);
      checkOutput("req_valid idle", 32'(req_valid), 32'd0);
      checkOutput("error after job", 32'(accel_error), 32'd0);
`ifdef MATMUL_AGEN_PERF_EN
      checkOutput("perf_cycles", perf_cycles, 32'(busySeen));
      checkOutput("perf_stalls", perf_stalls, 32'(stallSeen));
`else
      checkOutput("perf_cycles tied", perf_cycles, 32'd0);
      checkOutput("perf_stalls tied", perf_stalls, 32'd0);
`endif
   endtask

   task automatic checkBadStart(input string tag);
      applyStimulus();
      checkOutput({tag, " error"}, 32'(accel_error), 32'd1);
      checkOutput({tag, " done"}, 32'(accel_done), 32'd0);
      for (int c = 0; c < 3; c++) begin
         checkOutput({tag, " req_valid"}, 32'(req_valid), 32'd0);
         checkOutput({tag, " busy"}, 32'(accel_busy), 32'd0);
         @(negedge clk);
      end
   endtask

   // Directed sequence followed by randomized jobs.
   initial begin
      $display("[TB] start");
      repeat (3) @(negedge clk);
      checkOutput("reset req_valid", 32'(req_valid), 32'd0);
      checkOutput("reset busy", 32'(accel_busy), 32'd0);
      checkOutput("reset addr_a", req_addr_a, 32'd0);
      checkOutput("reset first_k", 32'(req_first_k), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("idle done", 32'(accel_done), 32'd0);
      checkOutput("idle error", 32'(accel_error), 32'd0);

      // Basic 2x2x2 int32 job, continuous ready.
      setJob(32'h1000, 32'h2000, 32'h3000, 16'd2, 16'd2, 16'd2, 8'd2, 16'd2, 16'd2, 16'd2);
      applyStimulus();
      runRequests(-1, 0, -1, -1, 1'b0);
      finishJob();

      // Same job with three stall cycles on the second request.
      applyStimulus();
      runRequests(1, 3, -1, -1, 1'b0);
      finishJob();
`ifdef MATMUL_AGEN_PERF_EN
      checkOutput("perf_stalls three", perf_stalls, 32'd3);
`endif

      // Invalid configurations.
      setJob(32'h1000, 32'h2000, 32'h3000, 16'd2, 16'd0, 16'd2, 8'd2, 16'd2, 16'd2, 16'd2);
      checkBadStart("kdim0");
      setJob(32'h1000, 32'h2000, 32'h3000, 16'd2, 16'd2, 16'd2, 8'd3, 16'd2, 16'd2, 16'd2);
      checkBadStart("dtype3");

      // int8 single-column job.
      setJob(32'h10, 32'h400, 32'h800, 16'd1, 16'd3, 16'd1, 8'd0, 16'd16, 16'd1, 16'd1);
      applyStimulus();
      runRequests(-1, 0, -1, -1, 1'b0);
      finishJob();

      // Soft reset after three handshakes, then a clean restart.
      setJob(32'h1000, 32'h2000, 32'h3000, 16'd2, 16'd2, 16'd2, 8'd2, 16'd2, 16'd2, 16'd2);
      applyStimulus();
      runRequests(-1, 0, 3, -1, 1'b0);
      accel_reset = 1'b1;
      @(negedge clk);
      accel_reset = 1'b0;
      checkOutput("abort req_valid", 32'(req_valid), 32'd0);
      checkOutput("abort busy", 32'(accel_busy), 32'd0);
      checkOutput("abort done", 32'(accel_done), 32'd0);
      checkOutput("abort perf_cycles", perf_cycles, 32'd0);
      applyStimulus();
      runRequests(-1, 0, -1, -1, 1'b0);
      finishJob();

      // Stray start mid-job with a different A base must be ignored.
      applyStimulus();
      runRequests(-1, 0, -1, 2, 1'b0);
      finishJob();

      // Randomized jobs with random backpressure.
      for (int t = 0; t < 8; t++) begin
         setJob($urandom, $urandom, $urandom,
                16'($urandom_range(1, 4)), 16'($urandom_range(1, 4)), 16'($urandom_range(1, 4)),
                8'($urandom_range(0, 2)),
                16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                16'($urandom_range(0, 65535)));
         applyStimulus();
         runRequests(-1, 0, -1, -1, 1'b1);
         finishJob();
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
